quad_decoder: RTL and testbench

//   Decodes 2-channel quadrature (A/B Gray-code) inputs from an incremental encoder into

---
 rtl/quad_dec_pkg.sv | 41 ++++
 rtl/quad_decoder_if.sv | 24 ++
 rtl/quad_sync_filter.sv | 85 ++++++++
 rtl/quad_decoder.sv | 132 +++++++++++++
 tb/tb_quad_decoder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/quad_dec_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Phase is {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
package quad_dec_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_10 = 2'b10,
      PH_11 = 2'b11,
      PH_01 = 2'b01
   } phase_e;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      TR_NONE    = 2'd0,
      TR_UP      = 2'd1,
      TR_ILLEGAL = 2'd2,
      TR_DN      = 2'd3
   } trans_e;

   // Position of a phase along the up sequence (0..3).
   function automatic logic [1:0] phase_pos(input logic [1:0] ph);
      logic [1:0] pos;
      unique case (ph)
         PH_00:   pos = 2'd0;
         PH_10:   pos = 2'd1;
         PH_11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   // Modulo-4 distance between positions: 1 = up, 3 = down, 2 = both bits changed.
   function automatic trans_e decode_trans(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] delta;
      delta = phase_pos(cur) - phase_pos(prev);
      return trans_e'(delta);
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Bus for the quadrature decoder: control and encoder pins in, step/dir/count/err out.
interface quad_decoder_if #(
   parameter int unsigned CNT_W = 16
);
   logic             en;
   logic             clr;
   logic             quad_a;
   logic             quad_b;
   logic             step;
   logic             dir;
   logic [CNT_W-1:0] count;
   logic             err;
   logic             err_flag;

   modport master (
      output en, clr, quad_a, quad_b,
      input  step, dir, count, err, err_flag
   );

   modport slave (
      input  en, clr, quad_a, quad_b,
      output step, dir, count, err, err_flag
   );
endinterface

// File: rtl/quad_sync_filter.sv
// Per-channel synchronizer with optional glitch filter.
// Build option: QUAD_FILTER_EN adds a FILT_LEN consecutive-sample filter after the sync chain.
// valid rises once the first real (post-reset) level is available.
module quad_sync_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic valid
);

   if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_cfg
      $error("quad_sync_filter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   sync_out;
   logic                   sync_vld;

   // Synchronizer chain; a parallel chain of ones marks which stages hold real samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign sync_vld = vld_q[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q;
   logic          level_q;
   logic          fvld_q;
   logic          accept;

   // Run length of identical samples, saturating at FILT_LEN.
   always_comb begin
      cnt_d = cnt_q;
      if (sync_vld) begin
         if (cnt_q != '0 && sync_out == last_q) begin
            cnt_d = (cnt_q == CW'(FILT_LEN)) ? cnt_q : cnt_q + CW'(1);
         end else begin
            cnt_d = CW'(1);
         end
      end
   end

   assign accept = sync_vld && (cnt_d == CW'(FILT_LEN));

   // Filter state: the level only moves after FILT_LEN equal samples in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         last_q  <= 1'b0;
         level_q <= 1'b0;
         fvld_q  <= 1'b0;
      end else if (sync_vld) begin
         cnt_q  <= cnt_d;
         last_q <= sync_out;
         if (accept) begin
            level_q <= sync_out;
            fvld_q  <= 1'b1;
         end
      end
   end

   assign level = level_q;
   assign valid = fvld_q;
`else
   assign level = sync_out;
   assign valid = sync_vld;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: two conditioned channels, previous-phase register,
// transition decode, step/dir/err outputs and a wrapping position counter.
// Build option: QUAD_FILTER_EN enables the per-channel glitch filter.
module quad_decoder
   import quad_dec_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   quad_decoder_if.slave  bus
);

   typedef enum logic {StWait, StRun} state_e;

   logic             a_lvl, a_vld, b_lvl, b_vld;
   logic [1:0]       cur;
   trans_e           trans;

   state_e           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic             err_flag_q, err_flag_d;
   logic [CNT_W-1:0] count_q, count_d;

   quad_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync_a (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.quad_a),
      .level (a_lvl),
      .valid (a_vld)
   );

   quad_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_sync_b (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (bus.quad_b),
      .level (b_lvl),
      .valid (b_vld)
   );

   assign cur   = {a_lvl, b_lvl};
   assign trans = decode_trans(prev_q, cur);

   // Next-state: first valid sample only seeds prev; afterwards decode every cycle.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      dir_d      = dir_q;
      count_d    = count_q;
      err_flag_d = err_flag_q;

      unique case (state_q)
         StWait: begin
            if (a_vld && b_vld) begin
               prev_d  = cur;
               state_d = StRun;
            end
         end
         StRun: begin
            // Phase is tracked even while disabled so re-enabling never sees a stale prev.
            prev_d = cur;
            if (bus.en) begin
               unique case (trans)
                  TR_UP: begin
                     step_d  = 1'b1;
                     dir_d   = DIR_UP;
                     count_d = count_q + CNT_W'(1);
                  end
                  TR_DN: begin
                     step_d  = 1'b1;
                     dir_d   = DIR_DN;
                     count_d = count_q - CNT_W'(1);
                  end
                  TR_ILLEGAL: begin
                     err_d      = 1'b1;
                     err_flag_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = StWait;
      endcase

      // Clear wins over a same-cycle step or error, but the pulses still go out.
      if (bus.clr) begin
         count_d    = '0;
         err_flag_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StWait;
         prev_q     <= 2'b00;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
         count_q    <= count_d;
      end
   end

   assign bus.step     = step_q;
   assign bus.dir      = dir_q;
   assign bus.err      = err_q;
   assign bus.err_flag = err_flag_q;
   assign bus.count    = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder; QUAD_FILTER_EN also enables the glitch scenario.
module tb_quad_decoder;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned FILT  = 3;
`ifdef QUAD_FILTER_EN
   localparam int unsigned LAT = SYNC + FILT + 1;
`else
   localparam int unsigned LAT = SYNC + 1;
`endif
   localparam int unsigned HOLD = LAT + 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   step_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   quad_decoder_if #(.CNT_W(CNT_W)) bus ();

   quad_decoder #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC),
      .FILT_LEN    (FILT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Pulse tallies used to count steps/errors over a whole stimulus sequence.
   always @(posedge clk) begin
      if (bus.step) step_cnt <= step_cnt + 1;
      if (bus.err)  err_cnt  <= err_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ph);
      bus.quad_a = ph[1];
      bus.quad_b = ph[0];
      tick(HOLD);
   endtask

   task automatic test_reset;
      int s0, e0;
      bus.quad_a = 1'b1; bus.quad_b = 1'b1; bus.en = 1'b1; bus.clr = 1'b0;
      s0 = step_cnt; e0 = err_cnt;
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(10);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b expected 0", bus.step); end
      tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      tests++; if (bus.count !== 16'd0) begin fails++; $display("FAIL reset_count: got %h expected 0000", bus.count); end
      tests++; if (bus.err_flag !== 1'b0) begin fails++; $display("FAIL reset_err_flag: got %b expected 0", bus.err_flag); end
      tests++; if (step_cnt - s0 != 0) begin fails++; $display("FAIL reset_no_steps: got %0d expected 0", step_cnt - s0); end
      tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL reset_no_errs: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_up_down;
      logic [1:0] up_seq [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
      logic [1:0] dn_seq [3] = '{2'b01, 2'b11, 2'b10};
      int s0, e0;
      // Walk from 11 to 00 with counting disabled.
      bus.en = 1'b0;
      drive(2'b01);
      drive(2'b00);
      bus.en = 1'b1;
      s0 = step_cnt; e0 = err_cnt;
      foreach (up_seq[i]) drive(up_seq[i]);
      tests++; if (step_cnt - s0 != 8) begin fails++; $display("FAIL up_steps: got %0d expected 8", step_cnt - s0); end
      tests++; if (bus.count !== 16'd8) begin fails++; $display("FAIL up_count: got %0d expected 8", bus.count); end
      tests++; if (bus.dir !== 1'b1) begin fails++; $display("FAIL up_dir: got %b expected 1", bus.dir); end
      s0 = step_cnt;
      foreach (dn_seq[i]) drive(dn_seq[i]);
      tests++; if (step_cnt - s0 != 3) begin fails++; $display("FAIL dn_steps: got %0d expected 3", step_cnt - s0); end
      tests++; if (bus.count !== 16'd5) begin fails++; $display("FAIL dn_count: got %0d expected 5", bus.count); end
      tests++; if (bus.dir !== 1'b0) begin fails++; $display("FAIL dn_dir: got %b expected 0", bus.dir); end
      tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL updn_errs: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_wrap;
      logic [1:0] dn_seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
      foreach (dn_seq[i]) drive(dn_seq[i]);
      tests++; if (bus.count !== 16'd0) begin fails++; $display("FAIL wrap_pre: got %h expected 0000", bus.count); end
      drive(2'b01);
      tests++; if (bus.count !== 16'hFFFF) begin fails++; $display("FAIL wrap_under: got %h expected ffff", bus.count); end
      drive(2'b00);
      tests++; if (bus.count !== 16'h0000) begin fails++; $display("FAIL wrap_over: got %h expected 0000", bus.count); end
      tests++; if (bus.dir !== 1'b1) begin fails++; $display("FAIL wrap_dir: got %b expected 1", bus.dir); end
   endtask

   task automatic test_latency;
      bus.quad_a = 1'b1; bus.quad_b = 1'b0;
      tick(LAT - 1);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL lat_early: got %b expected 0", bus.step); end
      tick(1);
      tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL lat_step: got %b expected 1", bus.step); end
      tests++; if (bus.count !== 16'd1) begin fails++; $display("FAIL lat_count: got %0d expected 1", bus.count); end
      tick(1);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL lat_one_cycle: got %b expected 0", bus.step); end
      tick(HOLD);
   endtask

   task automatic test_err;
      int s0;
      drive(2'b00);
      s0 = step_cnt;
      bus.quad_a = 1'b1; bus.quad_b = 1'b1;
      tick(LAT - 1);
      tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_early: got %b expected 0", bus.err); end
      tick(1);
      tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b expected 1", bus.err); end
      tests++; if (bus.err_flag !== 1'b1) begin fails++; $display("FAIL err_flag_set: got %b expected 1", bus.err_flag); end
      tick(1);
      tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_one_cycle: got %b expected 0", bus.err); end
      tick(HOLD);
      tests++; if (bus.err_flag !== 1'b1) begin fails++; $display("FAIL err_flag_sticky: got %b expected 1", bus.err_flag); end
      tests++; if (bus.count !== 16'd0) begin fails++; $display("FAIL err_count: got %0d expected 0", bus.count); end
      tests++; if (step_cnt - s0 != 0) begin fails++; $display("FAIL err_no_step: got %0d expected 0", step_cnt - s0); end
      bus.clr = 1'b1;
      tick(1);
      bus.clr = 1'b0;
      tests++; if (bus.err_flag !== 1'b0) begin fails++; $display("FAIL err_flag_clr: got %b expected 0", bus.err_flag); end
   endtask

   task automatic test_clr_step;
      drive(2'b01);
      tests++; if (bus.count !== 16'd1) begin fails++; $display("FAIL clr_pre: got %0d expected 1", bus.count); end
      bus.quad_a = 1'b0; bus.quad_b = 1'b0;
      tick(LAT - 1);
      bus.clr = 1'b1;
      tick(1);
      bus.clr = 1'b0;
      tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL clr_step_pulse: got %b expected 1", bus.step); end
      tests++; if (bus.count !== 16'd0) begin fails++; $display("FAIL clr_step_count: got %0d expected 0", bus.count); end
      tests++; if (bus.dir !== 1'b1) begin fails++; $display("FAIL clr_step_dir: got %b expected 1", bus.dir); end
      tick(HOLD);
   endtask

   task automatic test_en_off;
      logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      int s0, e0;
      bus.en = 1'b0;
      s0 = step_cnt; e0 = err_cnt;
      foreach (up_seq[i]) drive(up_seq[i]);
      tests++; if (step_cnt - s0 != 0) begin fails++; $display("FAIL en_off_steps: got %0d expected 0", step_cnt - s0); end
      tests++; if (bus.count !== 16'd0) begin fails++; $display("FAIL en_off_count: got %0d expected 0", bus.count); end
      bus.en = 1'b1;
      drive(2'b10);
      tests++; if (step_cnt - s0 != 1) begin fails++; $display("FAIL en_on_steps: got %0d expected 1", step_cnt - s0); end
      tests++; if (bus.count !== 16'd1) begin fails++; $display("FAIL en_on_count: got %0d expected 1", bus.count); end
      tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL en_on_errs: got %0d expected 0", err_cnt - e0); end
   endtask

`ifdef QUAD_FILTER_EN
   task automatic test_glitch;
      int s0, e0;
      s0 = step_cnt; e0 = err_cnt;
      bus.quad_a = 1'b0;
      tick(2);
      bus.quad_a = 1'b1;
      tick(HOLD);
      tests++; if (step_cnt - s0 != 0) begin fails++; $display("FAIL glitch_steps: got %0d expected 0", step_cnt - s0); end
      tests++; if (bus.count !== 16'd1) begin fails++; $display("FAIL glitch_count: got %0d expected 1", bus.count); end
      tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL glitch_errs: got %0d expected 0", err_cnt - e0); end
      bus.quad_b = 1'b1;
      tick(LAT - 1);
      tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL filt_early: got %b expected 0", bus.step); end
      tick(1);
      tests++; if (bus.step !== 1'b1) begin fails++; $display("FAIL filt_step: got %b expected 1", bus.step); end
      tests++; if (bus.count !== 16'd2) begin fails++; $display("FAIL filt_count: got %0d expected 2", bus.count); end
      tick(HOLD);
   endtask
`endif

   initial begin
      bus.en = 1'b0; bus.clr = 1'b0; bus.quad_a = 1'b0; bus.quad_b = 1'b0;
      test_reset;
      test_up_down;
      test_wrap;
      test_latency;
      test_err;
      test_clr_step;
      test_en_off;
`ifdef QUAD_FILTER_EN
      test_glitch;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
